// File: rtl/aes_key_fetch_if.sv
// Port-2 RAM bus and key handoff signals between aes_key_fetch, the shared key RAM and the AES core.
// key handoff: key_data is held stable while key_valid=1; a transfer happens on every cycle where key_valid && key_ready.
interface aes_key_fetch_if;
  logic [1:0]   address2;
  logic         chipselect2;
  logic         write2;
  logic [127:0] writedata2;
  logic [15:0]  byteenable2;
  logic         clken2;
  logic [127:0] readdata2;
  logic [127:0] key_data;
  logic         key_valid;
  logic         key_ready;
  logic         busy;

  modport master (
    output address2, chipselect2, write2, writedata2, byteenable2, clken2,
    output key_data, key_valid, busy,
    input  readdata2, key_ready
  );

  modport slave (
    input  address2, chipselect2, write2, writedata2, byteenable2, clken2,
    input  key_data, key_valid, busy,
    output readdata2, key_ready
  );
endinterface

// File: rtl/aes_key_fetch.sv
// Polls the HPS control word in the shared key RAM, hands new keys to the AES core
// and writes back a status word so software can see the key was consumed.
module aes_key_fetch #(
  parameter int unsigned POLL_CYCLES = 64,
  parameter int unsigned CTRL_ADDR   = 1,
  parameter int unsigned KEY_ADDR    = 0,
  parameter int unsigned STAT_ADDR   = 3
) (
  input  logic            clk,
  input  logic            reset,
  aes_key_fetch_if.master bus,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CTRL, S_CAP_CTRL, S_RD_KEY, S_CAP_KEY, S_OFFER, S_WR_STAT
  } state_t;

  localparam logic [15:0] POLL_LAST = 16'(POLL_CYCLES - 1);
  localparam logic [1:0]  CTRL_A    = 2'(CTRL_ADDR);
  localparam logic [1:0]  KEY_A     = 2'(KEY_ADDR);
  localparam logic [1:0]  STAT_A    = 2'(STAT_ADDR);

  state_t         state_q, state_d;
  logic [15:0]    poll_q, poll_d;
  logic [7:0]     seq_q, seq_d;
  logic [7:0]     last_seq_q, last_seq_d;
  logic [127:0]   key_data_q, key_data_d;
  logic           key_valid_q, key_valid_d;
  logic           busy_q, busy_d;
  logic [1:0]     addr_q, addr_d;
  logic           cs_q, cs_d;
  logic           wr_q, wr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [15:0]    be_q, be_d;
  logic           clken_q;

  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    seq_d      = seq_q;
    last_seq_d = last_seq_q;
    key_data_d = key_data_q;
    case (state_q)
      S_IDLE: begin
        if (poll_q == POLL_LAST) begin
          poll_d  = 16'd0;
          state_d = S_RD_CTRL;
        end else begin
          poll_d = poll_q + 16'd1;
        end
      end
      S_RD_CTRL: state_d = S_CAP_CTRL;
      S_CAP_CTRL: begin
        // Only a go with a sequence number different from the last one served is a new request.
        if (bus.readdata2[0] && (bus.readdata2[15:8] != last_seq_q)) begin
          seq_d   = bus.readdata2[15:8];
          state_d = S_RD_KEY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_KEY: state_d = S_CAP_KEY;
      S_CAP_KEY: begin
        key_data_d = bus.readdata2;
        state_d    = S_OFFER;
      end
      S_OFFER: begin
        if (key_valid_q && bus.key_ready) state_d = S_WR_STAT;
      end
      S_WR_STAT: begin
        last_seq_d = seq_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and handshake outputs are decoded from the next state so they register in step with it.
  always_comb begin
    cs_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = 2'd0;
    be_d        = 16'h0000;
    wdata_d     = 128'd0;
    key_valid_d = (state_d == S_OFFER);
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_RD_CTRL: begin
        cs_d   = 1'b1;
        addr_d = CTRL_A;
      end
      S_RD_KEY: begin
        cs_d   = 1'b1;
        addr_d = KEY_A;
      end
      S_WR_STAT: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = STAT_A;
        be_d    = 16'hFFFF;
        wdata_d = {112'd0, seq_d, 7'd0, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      poll_q      <= 16'd0;
      seq_q       <= 8'd0;
      last_seq_q  <= 8'd0;
      key_data_q  <= 128'd0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= 2'd0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 128'd0;
      be_q        <= 16'h0000;
      clken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_q      <= poll_d;
      seq_q       <= seq_d;
      last_seq_q  <= last_seq_d;
      key_data_q  <= key_data_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      clken_q     <= 1'b1;
    end
  end

  assign bus.address2    = addr_q;
  assign bus.chipselect2 = cs_q;
  assign bus.write2      = wr_q;
  assign bus.writedata2  = wdata_q;
  assign bus.byteenable2 = be_q;
  assign bus.clken2      = clken_q;
  assign bus.key_data    = key_data_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.busy        = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_aes_key_fetch.sv
// Bench for aes_key_fetch: shared-RAM model with an HPS write port, randomized requests,
// a reference model of which requests get served, and a monitor that checks handoffs and status writes.
module tb_aes_key_fetch;

  localparam int POLL = 4;
  localparam logic [1:0] A_KEY = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd3;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  aes_key_fetch_if bus ();

  aes_key_fetch #(.POLL_CYCLES(POLL), .CTRL_ADDR(1), .KEY_ADDR(0), .STAT_ADDR(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- shared RAM model ----------------
  logic [127:0] mem [0:3];
  logic [1:0]   raddr_q = 2'd0;
  logic         hps_we = 1'b0;
  logic [1:0]   hps_addr = 2'd0;
  logic [127:0] hps_wdata = 128'd0;

  initial for (int i = 0; i < 4; i++) mem[i] = 128'd0;

  always @(posedge clk) begin
    if (hps_we) mem[hps_addr] <= hps_wdata;
    if (bus.clken2 && bus.chipselect2) begin
      raddr_q <= bus.address2;
      if (bus.write2)
        for (int b = 0; b < 16; b++)
          if (bus.byteenable2[b]) mem[bus.address2][b*8 +: 8] <= bus.writedata2[b*8 +: 8];
    end
  end
  assign bus.readdata2 = mem[raddr_q];

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_fail = 0;
  logic [127:0] key_exp_q[$];
  logic [127:0] stat_exp_q[$];
  logic [7:0]   model_last = 8'd0;
  int hold_cfg = 0;
  int cyc = 0;
  int n_key_reads = 0, n_stat_wr = 0, last_rdctrl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a request is served iff go is set and seq differs from the last served seq.
  task automatic model_request(input bit go, input logic [7:0] seq, input logic [127:0] key,
                               output bit served);
    served = go && (seq != model_last);
    if (served) begin
      key_exp_q.push_back(key);
      stat_exp_q.push_back({112'd0, seq, 8'h01});
      model_last = seq;
    end
  endtask

  // ---------------- key_ready driver ----------------
  initial begin
    int vcnt;
    vcnt = 0;
    bus.key_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        vcnt = 0;
        bus.key_ready = 1'b0;
      end else begin
        if (bus.key_valid) vcnt++; else vcnt = 0;
        bus.key_ready = (hold_cfg == 0) ? 1'b1 : (bus.key_valid && vcnt >= hold_cfg + 1);
      end
    end
  end

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  logic [127:0] prev_key = 128'd0;
  int           valid_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      valid_len  = 0;
    end else begin
      if (bus.chipselect2 && !bus.write2 && bus.address2 == A_CTRL) last_rdctrl = cyc;
      if (bus.chipselect2 && !bus.write2 && bus.address2 == A_KEY) n_key_reads++;
      if (bus.chipselect2 && bus.write2) begin
        n_stat_wr++;
        check("stat_addr", 128'(bus.address2), 128'(A_STAT));
        check("stat_be", 128'(bus.byteenable2), 128'hFFFF);
        if (stat_exp_q.size() == 0) check("unexpected_stat_write", bus.writedata2, 128'hx);
        else check("stat_word", bus.writedata2, stat_exp_q.pop_front());
      end
      if (bus.key_valid) begin
        if (!prev_valid) begin
          check("latency", 128'(cyc - last_rdctrl), 128'd4);
          valid_len = 1;
        end else begin
          valid_len++;
          check("key_stable", bus.key_data, prev_key);
        end
        if (bus.key_ready) begin
          check("valid_len", 128'(valid_len), 128'(hold_cfg + 1));
          if (key_exp_q.size() == 0) check("unexpected_handshake", bus.key_data, 128'hx);
          else check("key_data", bus.key_data, key_exp_q.pop_front());
        end
      end
      prev_valid = bus.key_valid;
      prev_key   = bus.key_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hps_write(input logic [1:0] addr, input logic [127:0] data);
    @(negedge clk);
    hps_addr = addr; hps_wdata = data; hps_we = 1'b1;
    @(negedge clk);
    hps_we = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((key_exp_q.size() != 0 || stat_exp_q.size() != 0) && t < 400) begin
      @(negedge clk); t++;
    end
    check({name, "_drain_timeout"}, 128'(t >= 400), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!bus.key_valid && t < 200) begin
      @(negedge clk); t++;
    end
    check({name, "_valid_timeout"}, 128'(t >= 200), 128'd0);
  endtask

  task automatic issue(input bit go, input logic [7:0] seq, input logic [127:0] key, input string name);
    bit served;
    int kr0, sw0;
    kr0 = n_key_reads; sw0 = n_stat_wr;
    hps_write(A_KEY, key);
    model_request(go, seq, key, served);
    hps_write(A_CTRL, {112'd0, seq, 7'd0, go});
    if (served) wait_drain(name);
    else repeat (4 * (POLL + 2)) @(negedge clk);
    check({name, "_key_reads"}, 128'(n_key_reads - kr0), 128'(served ? 1 : 0));
    check({name, "_stat_writes"}, 128'(n_stat_wr - sw0), 128'(served ? 1 : 0));
    if (served) check({name, "_stat_mem"}, mem[A_STAT], {112'd0, seq, 8'h01});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ctrl_rd, key_rd, busy_c, val_c, t, sw0;
    logic [127:0] k;
    reset = 1'b1;
    @(negedge clk);
    check("rst_address2", 128'(bus.address2), 128'd0);
    check("rst_cs", 128'(bus.chipselect2), 128'd0);
    check("rst_write", 128'(bus.write2), 128'd0);
    check("rst_wdata", bus.writedata2, 128'd0);
    check("rst_be", 128'(bus.byteenable2), 128'd0);
    check("rst_clken", 128'(bus.clken2), 128'd0);
    check("rst_key_data", bus.key_data, 128'd0);
    check("rst_key_valid", 128'(bus.key_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("clken_after_reset", 128'(bus.clken2), 128'd1);

    // Idle polling: control word 0.
    t = 0;
    while (!(bus.chipselect2 && !bus.write2 && bus.address2 == A_CTRL) && t < 50) begin
      @(negedge clk); t++;
    end
    check("first_poll_timeout", 128'(t >= 50), 128'd0);
    ctrl_rd = 0; key_rd = 0; busy_c = 0; val_c = 0;
    for (int i = 0; i < 4 * (POLL + 2); i++) begin
      if (i > 0) @(negedge clk);
      if (bus.chipselect2 && !bus.write2 && bus.address2 == A_CTRL) ctrl_rd++;
      if (bus.chipselect2 && bus.address2 == A_KEY) key_rd++;
      if (bus.busy) busy_c++;
      if (bus.key_valid) val_c++;
    end
    check("idle_ctrl_reads", 128'(ctrl_rd), 128'd4);
    check("idle_key_reads", 128'(key_rd), 128'd0);
    check("idle_busy_cycles", 128'(busy_c), 128'd8);
    check("idle_valid_cycles", 128'(val_c), 128'd0);

    // seq=0 right after reset equals last_seq; go=0 with a new seq is also ignored.
    issue(1'b1, 8'h00, 128'hDEAD, "seq0_after_reset");
    issue(1'b0, 8'h05, 128'hBEEF, "go0");

    hold_cfg = 0;
    issue(1'b1, 8'h01, 128'h000102030405060708090A0B0C0D0E0F, "basic");

    // key_ready held low for 10 cycles; key rewritten in RAM during OFFER.
    hold_cfg = 10;
    k = {$urandom, $urandom, $urandom, $urandom};
    sw0 = n_stat_wr;
    hps_write(A_KEY, k);
    begin
      bit served;
      model_request(1'b1, 8'h02, k, served);
    end
    hps_write(A_CTRL, {112'd0, 8'h02, 8'h01});
    wait_valid("hold");
    hps_write(A_KEY, ~k);
    wait_drain("hold");
    check("hold_stat_writes", 128'(n_stat_wr - sw0), 128'd1);

    // Unchanged control word: no further service.
    issue(1'b1, 8'h02, 128'h1234, "reissue");

    hold_cfg = $urandom_range(0, 3);
    issue(1'b1, 8'hFF, {$urandom, $urandom, $urandom, $urandom}, "seq_ff");
    issue(1'b1, 8'h00, {$urandom, $urandom, $urandom, $urandom}, "seq_wrap_00");
    check("wrap_stat_seq", 128'(mem[A_STAT][15:8]), 128'h00);

    // Reset during OFFER: pending seq=1 is served again after release.
    hold_cfg = 40;
    k = {$urandom, $urandom, $urandom, $urandom};
    begin
      bit served;
      hps_write(A_KEY, k);
      model_request(1'b1, 8'h01, k, served);
      hps_write(A_CTRL, {112'd0, 8'h01, 8'h01});
    end
    wait_valid("mid_offer");
    repeat (2) @(negedge clk);
    sw0 = n_stat_wr;
    #2 reset = 1'b1;
    #1;
    check("async_key_valid", 128'(bus.key_valid), 128'd0);
    check("async_busy", 128'(bus.busy), 128'd0);
    check("async_cs", 128'(bus.chipselect2), 128'd0);
    check("async_clken", 128'(bus.clken2), 128'd0);
    check("async_key_data", bus.key_data, 128'd0);
    model_last = 8'h00;
    hold_cfg = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_drain("reserve");
    check("reserve_stat_writes", 128'(n_stat_wr - sw0), 128'd1);
    check("reserve_stat_mem", mem[A_STAT], 128'h0101);

    // Randomized requests.
    for (int i = 0; i < 10; i++) begin
      hold_cfg = $urandom_range(0, 5);
      issue(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            {$urandom, $urandom, $urandom, $urandom}, "random");
    end

    check("key_queue_empty", 128'(key_exp_q.size()), 128'd0);
    check("stat_queue_empty", 128'(stat_exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
